// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl
//
// Decode/issue pipeline control for the five-stage CPU. Owns the IF->ID latch
// and the ID->EXE latch, applies the hazard unit's stall to the ID stage,
// captures the already-forwarded rs/rt operands into the EXE input bus, and
// keeps two saturating 32-bit performance counters (stall cycles, issues).
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   IF_over/IF_pc/IF_inst : instruction offered by IF
//   ID_allow_in         : ID accepts from IF this cycle (combinational)
//   ID_valid/ID_pc/ID_inst: ID latch contents
//   stall_required      : load-use / mult-use stall from the hazard unit
//   rs_val/rt_val       : forwarded operands for the ID instruction
//   ID_over             : ID instruction may leave ID (combinational)
//   EXE_over            : EXE instruction completes this cycle
//   MEM_allow_in        : MEM accepts from EXE this cycle
//   EXE_valid/EXE_pc/EXE_inst/EXE_rs_val/EXE_rt_val : EXE latch contents
//   cancel              : exception / ERET flush
//   cnt_clr             : synchronous clear of both counters
//   stall_cnt/issue_cnt : saturating performance counters
module id_issue_ctrl #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IF_over,
  input  logic [PC_W-1:0]   IF_pc,
  input  logic [INST_W-1:0] IF_inst,
  output logic              ID_allow_in,
  output logic              ID_valid,
  output logic [PC_W-1:0]   ID_pc,
  output logic [INST_W-1:0] ID_inst,
  input  logic              stall_required,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              ID_over,
  input  logic              EXE_over,
  input  logic              MEM_allow_in,
  output logic              EXE_valid,
  output logic [PC_W-1:0]   EXE_pc,
  output logic [INST_W-1:0] EXE_inst,
  output logic [DATA_W-1:0] EXE_rs_val,
  output logic [DATA_W-1:0] EXE_rt_val,
  input  logic              cancel,
  input  logic              cnt_clr,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       issue_cnt
);

  logic exe_allow_in;
  logic issue;
  logic stall_cycle;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Handshake terms: all combinational from latch state and neighbour status.
  // stall_required depends only on register outputs, so no loop through here.
  assign exe_allow_in = ~EXE_valid | (EXE_over & MEM_allow_in);
  assign ID_over      = ID_valid & ~stall_required;
  assign ID_allow_in  = ~ID_valid | (ID_over & exe_allow_in);
  assign issue        = ID_over & exe_allow_in & ~cancel;
  assign stall_cycle  = ID_valid & stall_required & ~cancel;

  // IF -> ID boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID_valid <= 1'b0;
      ID_pc    <= '0;
      ID_inst  <= '0;
    end else begin
      if (cancel)
        ID_valid <= 1'b0;
      else if (ID_allow_in)
        ID_valid <= IF_over;
      if (IF_over & ID_allow_in & ~cancel) begin
        ID_pc   <= IF_pc;
        ID_inst <= IF_inst;
      end
    end
  end

  // ID -> EXE boundary; a stalled or empty ID shifts a bubble into EXE.
  // Operands are captured in the issue cycle, i.e. after forwarding settles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EXE_valid  <= 1'b0;
      EXE_pc     <= '0;
      EXE_inst   <= '0;
      EXE_rs_val <= '0;
      EXE_rt_val <= '0;
    end else begin
      if (cancel)
        EXE_valid <= 1'b0;
      else if (exe_allow_in)
        EXE_valid <= ID_over;
      if (issue) begin
        EXE_pc     <= ID_pc;
        EXE_inst   <= ID_inst;
        EXE_rs_val <= rs_val;
        EXE_rt_val <= rt_val;
      end
    end
  end

  // Performance counters; clear wins even during a flush.
  // Stall and issue are mutually exclusive for the same ID instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (stall_cycle)
        stall_cnt <= sat_inc(stall_cnt);
      if (issue)
        issue_cnt <= sat_inc(issue_cnt);
    end
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
module tb_id_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        IF_over;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;
  logic        ID_allow_in;
  logic        ID_valid;
  logic [31:0] ID_pc;
  logic [31:0] ID_inst;
  logic        stall_required;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        ID_over;
  logic        EXE_over;
  logic        MEM_allow_in;
  logic        EXE_valid;
  logic [31:0] EXE_pc;
  logic [31:0] EXE_inst;
  logic [31:0] EXE_rs_val;
  logic [31:0] EXE_rt_val;
  logic        cancel;
  logic        cnt_clr;
  logic [31:0] stall_cnt;
  logic [31:0] issue_cnt;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_issue_ctrl #(.PC_W(32), .INST_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .IF_over(IF_over), .IF_pc(IF_pc), .IF_inst(IF_inst),
    .ID_allow_in(ID_allow_in), .ID_valid(ID_valid), .ID_pc(ID_pc), .ID_inst(ID_inst),
    .stall_required(stall_required), .rs_val(rs_val), .rt_val(rt_val),
    .ID_over(ID_over), .EXE_over(EXE_over), .MEM_allow_in(MEM_allow_in),
    .EXE_valid(EXE_valid), .EXE_pc(EXE_pc), .EXE_inst(EXE_inst),
    .EXE_rs_val(EXE_rs_val), .EXE_rt_val(EXE_rt_val),
    .cancel(cancel), .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA500_0000;
  endfunction

  function automatic logic [31:0] rt_of(input logic [31:0] rs);
    return rs ^ 32'hFFFF_0000;
  endfunction

  function automatic logic [31:0] rs_of(input logic [31:0] pc);
    return 32'h1000_0000 + pc * 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic v, input logic [31:0] pc);
    IF_over = v;
    IF_pc   = pc;
    IF_inst = inst_of(pc);
  endtask

  task automatic set_ops(input logic [31:0] rs);
    rs_val = rs;
    rt_val = rt_of(rs);
  endtask

  task automatic sb_push(input logic [31:0] pc, input logic [31:0] rs);
    exp_t e;
    e.pc = pc;
    e.rs = rs;
    sb.push_back(e);
  endtask

  // Compare the EXE latch against the oldest outstanding expected issue.
  task automatic check_exe(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      errors++;
      $error("FAIL %s: observed EXE load expected none queued", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'd0, EXE_valid}, 32'd1);
      chk({tag, "_pc"},    EXE_pc,     e.pc);
      chk({tag, "_inst"},  EXE_inst,   inst_of(e.pc));
      chk({tag, "_rs"},    EXE_rs_val, e.rs);
      chk({tag, "_rt"},    EXE_rt_val, rt_of(e.rs));
    end
  endtask

  initial begin
    rst = 1'b1;
    set_if(1'b0, 32'd0);
    set_ops(32'd0);
    stall_required = 1'b0;
    EXE_over = 1'b1;
    MEM_allow_in = 1'b1;
    cancel = 1'b0;
    cnt_clr = 1'b0;
    tick();
    tick();
    chk("rst_id_valid",  {31'd0, ID_valid},  32'd0);
    chk("rst_exe_valid", {31'd0, EXE_valid}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_issue_cnt", issue_cnt, 32'd0);
    chk("rst_exe_pc",    EXE_pc,    32'd0);
    rst = 1'b0;

    // Streaming 0x100, 0x104, 0x108
    set_if(1'b1, 32'h100);
    #1 chk("stream_allow", {31'd0, ID_allow_in}, 32'd1);
    tick();
    chk("stream_id_pc", ID_pc, 32'h100);
    chk("stream_exe_empty", {31'd0, EXE_valid}, 32'd0);
    set_if(1'b1, 32'h104); set_ops(rs_of(32'h100)); sb_push(32'h100, rs_of(32'h100));
    tick();
    check_exe("stream0");
    set_if(1'b1, 32'h108); set_ops(rs_of(32'h104)); sb_push(32'h104, rs_of(32'h104));
    tick();
    check_exe("stream1");
    set_if(1'b0, 32'h0); set_ops(rs_of(32'h108)); sb_push(32'h108, rs_of(32'h108));
    tick();
    check_exe("stream2");
    chk("stream_issue_cnt", issue_cnt, 32'd3);
    chk("stream_id_empty", {31'd0, ID_valid}, 32'd0);

    // Load-use stall on 0x104
    set_if(1'b1, 32'h104);
    tick();
    chk("lu_bubble_prior", {31'd0, EXE_valid}, 32'd0);
    chk("lu_id_pc", ID_pc, 32'h104);
    set_if(1'b1, 32'h108); stall_required = 1'b1; set_ops(32'hDEAD);
    #1;
    chk("lu_allow_in", {31'd0, ID_allow_in}, 32'd0);
    chk("lu_id_over",  {31'd0, ID_over},     32'd0);
    tick();
    chk("lu_bubble",    {31'd0, EXE_valid}, 32'd0);
    chk("lu_id_hold",   ID_pc, 32'h104);
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    stall_required = 1'b0; set_ops(32'hBEEF); sb_push(32'h104, 32'hBEEF);
    #1 chk("lu_release_allow", {31'd0, ID_allow_in}, 32'd1);
    tick();
    check_exe("lu_issue");
    chk("lu_id_next", ID_pc, 32'h108);
    chk("lu_issue_cnt", issue_cnt, 32'd4);

    // Back-pressure with both latches full
    set_if(1'b1, 32'h10C); set_ops(rs_of(32'h108)); sb_push(32'h108, rs_of(32'h108));
    tick();
    check_exe("bp_fill");
    MEM_allow_in = 1'b0;
    set_if(1'b1, 32'h110); set_ops(rs_of(32'h10C));
    #1 chk("bp_allow_in", {31'd0, ID_allow_in}, 32'd0);
    tick();
    tick();
    chk("bp_exe_valid", {31'd0, EXE_valid}, 32'd1);
    chk("bp_exe_pc",    EXE_pc, 32'h108);
    chk("bp_id_valid",  {31'd0, ID_valid}, 32'd1);
    chk("bp_id_pc",     ID_pc, 32'h10C);
    chk("bp_issue_cnt", issue_cnt, 32'd5);
    chk("bp_stall_cnt", stall_cnt, 32'd1);
    MEM_allow_in = 1'b1;
    set_if(1'b0, 32'h0); sb_push(32'h10C, rs_of(32'h10C));
    tick();
    check_exe("bp_release");
    chk("bp_rel_issue_cnt", issue_cnt, 32'd6);

    // Cancel while an issue and an IF load would happen
    set_if(1'b1, 32'h120);
    tick();
    set_if(1'b1, 32'h124); set_ops(rs_of(32'h120)); sb_push(32'h120, rs_of(32'h120));
    tick();
    check_exe("cx_fill");
    cancel = 1'b1; set_if(1'b1, 32'h128); set_ops(rs_of(32'h124));
    tick();
    cancel = 1'b0;
    chk("cx_id_valid",  {31'd0, ID_valid},  32'd0);
    chk("cx_exe_valid", {31'd0, EXE_valid}, 32'd0);
    chk("cx_issue_cnt", issue_cnt, 32'd7);
    chk("cx_id_pc",     ID_pc,  32'h124);
    chk("cx_exe_pc",    EXE_pc, 32'h120);
    // Cancel during a stall
    set_if(1'b1, 32'h130);
    tick();
    cancel = 1'b1; stall_required = 1'b1; set_if(1'b1, 32'h134);
    tick();
    cancel = 1'b0; stall_required = 1'b0;
    chk("cxs_id_valid",  {31'd0, ID_valid},  32'd0);
    chk("cxs_exe_valid", {31'd0, EXE_valid}, 32'd0);
    chk("cxs_stall_cnt", stall_cnt, 32'd1);

    // Saturation
    set_if(1'b1, 32'h140);
    tick();
    set_if(1'b0, 32'h0); stall_required = 1'b1;
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt;
    chk("sat_preload", stall_cnt, 32'hFFFF_FFFE);
    tick();
    chk("sat_stall_1", stall_cnt, 32'hFFFF_FFFF);
    tick();
    tick();
    chk("sat_stall_3", stall_cnt, 32'hFFFF_FFFF);
    chk("sat_id_hold", ID_pc, 32'h140);
    force dut.issue_cnt = 32'hFFFF_FFFF;
    #1 release dut.issue_cnt;
    stall_required = 1'b0; set_ops(rs_of(32'h140)); sb_push(32'h140, rs_of(32'h140));
    tick();
    check_exe("sat_issue");
    chk("sat_issue_cnt", issue_cnt, 32'hFFFF_FFFF);
    cnt_clr = 1'b1; cancel = 1'b1;
    tick();
    cnt_clr = 1'b0; cancel = 1'b0;
    chk("clr_stall_cnt", stall_cnt, 32'd0);
    chk("clr_issue_cnt", issue_cnt, 32'd0);

    // Asynchronous reset mid-stream
    set_if(1'b1, 32'h150);
    tick();
    set_if(1'b1, 32'h154); set_ops(rs_of(32'h150)); sb_push(32'h150, rs_of(32'h150));
    tick();
    check_exe("ar_fill");
    chk("ar_issue_cnt", issue_cnt, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("ar_id_valid",  {31'd0, ID_valid},  32'd0);
    chk("ar_exe_valid", {31'd0, EXE_valid}, 32'd0);
    chk("ar_stall_cnt", stall_cnt, 32'd0);
    chk("ar_issue_cnt0", issue_cnt, 32'd0);
    chk("ar_exe_pc",    EXE_pc, 32'd0);
    chk("ar_id_pc",     ID_pc,  32'd0);
    tick();
    rst = 1'b0;
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

Decode/issue pipeline control for the five-stage CPU. Holds the IF→ID latch and the ID→EXE latch, and applies the hazard unit's `stall_required` to the ID stage. It registers the already-forwarded rs/rt operands into the EXE-stage input bus. Its `EXE_valid` output is the same EXE-valid bit the hazard unit consumes. It also keeps two 32-bit saturating performance counters: stall cycles and issued instructions.

## Interface
- `PC_W`, default 32: PC width.
- `INST_W`, default 32: instruction width.
- `DATA_W`, default 32: operand width.

Ports:
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: reset. Asynchronous and active-high.
- `IF_over` input 1: IF presents a valid instruction this cycle.
- `IF_pc` input PC_W: PC of the IF instruction.
- `IF_inst` input INST_W: IF instruction word.
- `ID_allow_in` output 1: ID accepts from IF this cycle (combinational).
- `ID_valid` output 1: ID latch holds a live instruction.
- `ID_pc` output PC_W: PC held in the ID latch.
- `ID_inst` output INST_W: instruction held in the ID latch; feeds decode and the hazard unit.
- `stall_required` input 1: load-use/mult-use stall for the ID instruction (combinational from the hazard unit).
- `rs_val` input DATA_W: forwarded rs value for the ID instruction.
- `rt_val` input DATA_W: forwarded rt value for the ID instruction.
- `ID_over` output 1: `ID_valid & ~stall_required` (combinational).
- `EXE_over` input 1: the EXE instruction completes this cycle.
- `MEM_allow_in` input 1: MEM accepts from EXE this cycle.
- `EXE_valid` output 1: EXE latch holds a live instruction.
- `EXE_pc` output PC_W: PC in the EXE latch.
- `EXE_inst` output INST_W: instruction in the EXE latch.
- `EXE_rs_val` output DATA_W: rs operand in the EXE latch.
- `EXE_rt_val` output DATA_W: rt operand in the EXE latch.
- `cancel` input 1: exception/ERET flush.
- `cnt_clr` input 1: synchronous clear of both counters.
- `stall_cnt` output 32: count of stall cycles.
- `issue_cnt` output 32: count of issued instructions.

## Operation
**Combinational terms**
- `EXE_allow_in = ~EXE_valid | (EXE_over & MEM_allow_in)`
- `ID_allow_in = ~ID_valid | (ID_over & EXE_allow_in)`
- `issue = ID_over & EXE_allow_in & ~cancel`

**ID latch**
- If `cancel`: `ID_valid <= 0`.
- Else if `ID_allow_in`: `ID_valid <= IF_over`.
- `ID_pc` and `ID_inst` load only on `IF_over & ID_allow_in & ~cancel`; otherwise they hold.

**EXE latch**
- If `cancel`: `EXE_valid <= 0`.
- Else if `EXE_allow_in`: `EXE_valid <= ID_over`, so a stall or an empty ID inserts a bubble.
- The EXE payload (`pc`, `inst`, `rs_val`, `rt_val`) loads only on `issue`. Operands are sampled in the issue cycle, i.e. after forwarding.

**Stall behaviour**
- While `ID_valid & stall_required`, the ID latch holds its contents and `ID_allow_in` is 0.
- IF must hold its instruction while `ID_allow_in` is 0.

**Counters**
- `cnt_clr` has priority: both counters load 0.
- Otherwise `stall_cnt` increments when `ID_valid & stall_required & ~cancel`.
- Otherwise `issue_cnt` increments on `issue`.
- Both counters saturate at 0xFFFFFFFF and never wrap.

**Priorities and edge cases**
- `cancel` overrides load, issue and counter increments in the same cycle. `cnt_clr` is still honoured when `cancel` is high.
- Simultaneous drain and fill is allowed: when `ID_over & EXE_allow_in & IF_over`, ID takes the new instruction and EXE takes the old one in the same edge.
- Back-pressure: when `EXE_allow_in` is 0, ID holds even with no stall, and `issue_cnt` does not increment.

**Reset**
- On `rst`, every output register goes to 0: `ID_valid`, `EXE_valid`, all pc/inst/operand fields, and both counters.
- `rst` asserted mid-operation kills all in-flight instructions immediately (asynchronous).

## Timing
- Latency from IF to ID: an instruction accepted at edge N is visible in ID (`ID_valid=1`) after edge N.
- Latency from ID to EXE: with no stall and `EXE_allow_in=1`, the instruction moves to EXE one edge later.
- Each stall cycle adds exactly one cycle of ID residency and one EXE bubble.
- Throughput: 1 instruction per cycle with no hazards and no back-pressure.
- `ID_allow_in`, `ID_over` and `EXE_allow_in` are purely combinational. There is no registered handshake.
- `stall_required` is combinational from `ID_inst` and `EXE_valid`. That is a legal path because both are register outputs; no loop passes through `ID_allow_in`.

## Test plan
1. **Reset:** assert `rst` mid-stream with both latches valid. Required: `ID_valid`, `EXE_valid` and both counters read 0 immediately, before the next edge.
2. **Streaming:** `IF_over=1` with pc 0x100, 0x104, 0x108 on consecutive cycles; `EXE_over=MEM_allow_in=1`; no stall. Required: `EXE_pc` reads 0x100, 0x104, 0x108 on cycles 2, 3, 4; `issue_cnt=3`.
3. **Load-use stall:** hold `stall_required=1` for 1 cycle while ID holds pc 0x104, with `rs_val` changing from 0xDEAD to 0xBEEF on the release cycle. Required: one bubble (`EXE_valid=0`), then `EXE_pc=0x104` and `EXE_rs_val=0xBEEF`; `stall_cnt=1`; `ID_allow_in=0` during the stall.
4. **Back-pressure:** hold `MEM_allow_in=0` with EXE full and ID full. Required: both latches hold; `ID_allow_in=0`; `issue_cnt` unchanged; `stall_cnt` unchanged.
5. **Cancel:** assert `cancel` together with `IF_over`, `issue` and `stall_required` in one cycle. Required: next cycle `ID_valid=0`, `EXE_valid=0`, counters unchanged.
6. **Saturation:** preload `stall_cnt` to 0xFFFFFFFE by stalling, then stall 3 more cycles. Required: `stall_cnt` ends at 0xFFFFFFFF. Then pulse `cnt_clr`: both counters read 0.
